// File: rtl/ram_loader.sv
// ram_loader
// ----------
// Pulls a little-endian byte stream into program memory, one 16-bit word per
// pair of bytes. The first two words must be the magic "ASRM"
// (16'h5341, 16'h4D52), otherwise the load aborts before anything is written.
// A load also aborts if the requested length is out of range, or if the byte
// stream goes quiet for TIMEOUT_CYCLES consecutive cycles while a byte is
// expected.
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous active-high reset
//   start       single-cycle load request (honoured in IDLE/DONE/ERROR)
//   load_words  words to load including the two magic words, sampled on start
//   in_byte     incoming byte
//   in_valid    in_byte is valid
//   in_ready    loader takes in_byte this cycle (LOW/HIGH only)
//   wr_en       program-memory write strobe, one cycle per word
//   wr_addr     program-memory word address (0 outside WRITE)
//   wr_data     program-memory word (0 outside WRITE)
//   busy        load in progress
//   done        last load completed (held until reset/start)
//   error       last load aborted (held until reset/start)
module ram_loader #(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   load_words,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

    // Legal lengths are 2 .. 2**ADDR_WIDTH words inclusive.
    localparam logic [ADDR_WIDTH:0] MIN_WORDS = {{(ADDR_WIDTH-1){1'b0}}, 2'b10};
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    localparam logic [15:0] MAGIC0 = 16'h5341;
    localparam logic [15:0] MAGIC1 = 16'h4D52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_reg,   state_next;
    logic [ADDR_WIDTH-1:0]   index_reg,   index_next;
    logic [ADDR_WIDTH:0]     total_reg,   total_next;
    logic [7:0]              low_reg,     low_next;
    logic [7:0]              high_reg,    high_next;
    logic [TW-1:0]           timeout_reg, timeout_next;

    logic                    transfer;
    logic                    length_bad;
    logic                    magic_bad;
    logic                    last_word;
    logic [TW-1:0]           timeout_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            index_reg   <= '0;
            total_reg   <= '0;
            low_reg     <= '0;
            high_reg    <= '0;
            timeout_reg <= '0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            total_reg   <= total_next;
            low_reg     <= low_next;
            high_reg    <= high_next;
            timeout_reg <= timeout_next;
        end
    end

    assign in_ready    = (state_reg == S_LOW) || (state_reg == S_HIGH);
    assign transfer    = in_valid && in_ready;
    assign length_bad  = (load_words < MIN_WORDS) || (load_words > MAX_WORDS);
    assign last_word   = ({1'b0, index_reg} == (total_reg - ONE_WORD));
    assign timeout_inc = timeout_reg + TW'(1);

    // Only indices 0 and 1 carry the magic; later words are unrestricted.
    assign magic_bad = ((index_reg == '0)            && ({high_reg, low_reg} != MAGIC0)) ||
                       ((index_reg == ADDR_WIDTH'(1)) && ({high_reg, low_reg} != MAGIC1));

    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        total_next   = total_reg;
        low_next     = low_reg;
        high_next    = high_reg;
        timeout_next = timeout_reg;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
                done  = (state_reg == S_DONE);
                error = (state_reg == S_ERROR);
                if (start) begin
                    index_next   = '0;
                    timeout_next = '0;
                    total_next   = load_words;
                    state_next   = length_bad ? S_ERROR : S_LOW;
                end
            end

            S_LOW, S_HIGH: begin
                busy = 1'b1;
                if (transfer) begin
                    timeout_next = '0;
                    if (state_reg == S_LOW) begin
                        low_next   = in_byte;
                        state_next = S_HIGH;
                    end else begin
                        high_next  = in_byte;
                        state_next = S_WRITE;
                    end
                end else begin
                    // The abort happens on the edge where the idle count
                    // reaches the limit, so a gap of TIMEOUT_CYCLES-1 survives.
                    timeout_next = timeout_inc;
                    if (timeout_inc == TIMEOUT_LIMIT) begin
                        state_next = S_ERROR;
                    end
                end
            end

            S_WRITE: begin
                busy    = 1'b1;
                wr_addr = index_reg;
                wr_data = {high_reg, low_reg};
                if (magic_bad) begin
                    state_next = S_ERROR;
                end else begin
                    wr_en = 1'b1;
                    if (last_word) begin
                        state_next = S_DONE;
                    end else begin
                        index_next = index_reg + ADDR_WIDTH'(1);
                        state_next = S_LOW;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_loader.sv
// Testbench for ram_loader: a table of whole-load vectors followed by
// hand-written sequences for timeout, reset mid-load and start while busy.
module tb_ram_loader;

    localparam int AW = 14;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW:0]   load_words;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          done;
    logic          error;

    ram_loader #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_words (load_words),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Captured write strobes, sampled mid-cycle.
    logic [AW-1:0] cap_addr[$];
    logic [15:0]   cap_data[$];

    always @(negedge clk) begin
        if (wr_en) begin
            cap_addr.push_back(wr_addr);
            cap_data.push_back(wr_data);
        end
    end

    typedef struct packed {
        logic [AW:0] lw;
        int          nbytes;
        logic [63:0] bytes;     // byte i at [8i +: 8]
        int          stall;
        logic        exp_done;
        logic        exp_error;
        int          exp_nwr;
        logic [63:0] words;     // expected word i at [16i +: 16]
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [AW:0] lw);
        start      = 1'b1;
        load_words = lw;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    // Waits for in_ready, idles for 'stall' ready cycles, then transfers one byte.
    task automatic send_byte(input logic [7:0] b, input int stall);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("ready_wait", 32'(in_ready), 32'd1);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("end_wait", 32'(done || error), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_wr_en"},    32'(wr_en),    32'd0);
        check({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
        check({tag, "_wr_data"},  32'(wr_data),  32'd0);
    endtask

    function automatic vec_t mk(input logic [AW:0] lw, input int nbytes, input logic [63:0] bytes,
                                input int stall, input logic d, input logic e, input int nwr,
                                input logic [63:0] words);
        vec_t v;
        v.lw = lw; v.nbytes = nbytes; v.bytes = bytes; v.stall = stall;
        v.exp_done = d; v.exp_error = e; v.exp_nwr = nwr; v.words = words;
        return v;
    endfunction

    initial begin
        logic [63:0] bv;
        logic [63:0] wv;

        // Nominal: 41 53 52 4D 3C 2D -> 5341, 4D52, 2D3C.
        vecs[0] = mk(15'd3, 6, 64'h0000_2D3C_4D52_5341, 0, 1'b1, 1'b0, 3, 64'h0000_2D3C_4D52_5341);
        // Same load with a 7-cycle gap before every byte: still under the timeout.
        vecs[1] = mk(15'd3, 6, 64'h0000_2D3C_4D52_5341, 7, 1'b1, 1'b0, 3, 64'h0000_2D3C_4D52_5341);
        // Bad first magic.
        vecs[2] = mk(15'd4, 2, 64'h0000_0000_0000_0000, 0, 1'b0, 1'b1, 0, 64'h0);
        // Illegal lengths.
        vecs[3] = mk(15'd1,     0, 64'h0, 0, 1'b0, 1'b1, 0, 64'h0);
        vecs[4] = mk(15'd16385, 0, 64'h0, 0, 1'b0, 1'b1, 0, 64'h0);
        vecs[5] = mk(15'd0,     0, 64'h0, 0, 1'b0, 1'b1, 0, 64'h0);
        // Minimum legal length: magic only.
        vecs[6] = mk(15'd2, 4, 64'h0000_0000_4D52_5341, 0, 1'b1, 1'b0, 2, 64'h0000_0000_4D52_5341);
        // First magic fine, second wrong (41 53 00 11): one write then abort.
        vecs[7] = mk(15'd4, 4, 64'h0000_0000_1100_5341, 0, 1'b0, 1'b1, 1, 64'h0000_0000_0000_5341);

        reset = 1'b1; start = 1'b0; load_words = '0; in_byte = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_error", 32'(error), 32'd0);
        check_idle_outputs("rst");

        // ---------------- table-driven loads ----------------
        for (int v = 0; v < 8; v++) begin
            cap_addr.delete();
            cap_data.delete();
            do_start(vecs[v].lw);
            if (vecs[v].nbytes == 0) begin
                check($sformatf("v%0d_len_err_next", v), 32'(error), 32'd1);
            end
            bv = vecs[v].bytes;
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                send_byte(bv[8*i +: 8], vecs[v].stall);
            end
            wait_end();
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_done", v),  32'(done),  32'(vecs[v].exp_done));
            check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_error));
            check($sformatf("v%0d_busy", v),  32'(busy),  32'd0);
            check_idle_outputs($sformatf("v%0d", v));
            check($sformatf("v%0d_nwr", v), 32'(cap_addr.size()), 32'(vecs[v].exp_nwr));
            wv = vecs[v].words;
            for (int i = 0; i < vecs[v].exp_nwr && i < cap_addr.size(); i++) begin
                check($sformatf("v%0d_addr%0d", v, i), 32'(cap_addr[i]), 32'(i));
                check($sformatf("v%0d_data%0d", v, i), 32'(cap_data[i]), 32'(wv[16*i +: 16]));
            end
        end

        // ---------------- timeout: 8 idle cycles after first byte ----------------
        cap_addr.delete();
        cap_data.delete();
        do_start(15'd3);
        send_byte(8'h41, 0);
        repeat (7) @(posedge clk);
        #1;
        check("to_7_error", 32'(error), 32'd0);
        check("to_7_busy",  32'(busy),  32'd1);
        @(posedge clk); #1;
        check("to_8_error", 32'(error), 32'd1);
        check("to_8_ready", 32'(in_ready), 32'd0);
        check("to_nwr", 32'(cap_addr.size()), 32'd0);

        // ---------------- reset in HIGH of word 2 ----------------
        cap_addr.delete();
        cap_data.delete();
        do_start(15'd4);
        send_byte(8'h41, 0);
        send_byte(8'h53, 0);
        send_byte(8'h52, 0);
        send_byte(8'h4D, 0);
        send_byte(8'h3C, 0);
        check("mid_in_high", 32'(in_ready && busy), 32'd1);
        reset = 1'b1; start = 1'b1; load_words = 15'd2; in_byte = 8'h2D; in_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("mid_rst_busy",  32'(busy),  32'd0);
        check("mid_rst_done",  32'(done),  32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check_idle_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_nwr", 32'(cap_addr.size()), 32'd2);
        cap_addr.delete();
        cap_data.delete();
        do_start(15'd3);
        send_byte(8'h41, 0);
        send_byte(8'h53, 0);
        // Word lands exactly one cycle after its high byte.
        check("reload_wr_en",   32'(wr_en),   32'd1);
        check("reload_wr_addr", 32'(wr_addr), 32'd0);
        check("reload_wr_data", 32'(wr_data), 32'h5341);
        send_byte(8'h52, 0);
        send_byte(8'h4D, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        wait_end();
        check("reload_done", 32'(done), 32'd1);
        check("reload_nwr",  32'(cap_addr.size()), 32'd3);
        if (cap_addr.size() == 3) begin
            check("reload_addr2", 32'(cap_addr[2]), 32'd2);
            check("reload_data2", 32'(cap_data[2]), 32'h55AA);
        end

        // ---------------- start while busy, then restart from DONE ----------------
        cap_addr.delete();
        cap_data.delete();
        do_start(15'd3);
        send_byte(8'h41, 0);
        send_byte(8'h53, 0);
        @(posedge clk); #1;                 // now in LOW of word 1
        check("busy_start_in_low", 32'(in_ready), 32'd1);
        do_start(15'd2);
        check("busy_start_busy",  32'(busy),  32'd1);
        check("busy_start_error", 32'(error), 32'd0);
        send_byte(8'h52, 0);
        send_byte(8'h4D, 0);
        send_byte(8'h3C, 0);
        send_byte(8'h2D, 0);
        wait_end();
        check("busy_start_done", 32'(done), 32'd1);
        check("busy_start_nwr",  32'(cap_addr.size()), 32'd3);
        repeat (3) @(posedge clk);
        #1;
        check("done_sticky", 32'(done), 32'd1);
        cap_addr.delete();
        cap_data.delete();
        do_start(15'd2);
        check("restart_done_clr", 32'(done), 32'd0);
        check("restart_busy",     32'(busy), 32'd1);
        send_byte(8'h41, 0);
        send_byte(8'h53, 0);
        send_byte(8'h52, 0);
        send_byte(8'h4D, 0);
        wait_end();
        check("restart_done", 32'(done), 32'd1);
        check("restart_nwr",  32'(cap_addr.size()), 32'd2);
        if (cap_addr.size() == 2) begin
            check("restart_addr1", 32'(cap_addr[1]), 32'd1);
            check("restart_data1", 32'(cap_data[1]), 32'h4D52);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
